// File: rtl/fp_mac_seq.sv
// Sequencer that runs one MUL / ADD / MULADD / MAC operation per start/done handshake
// over an FP multiplier and adder whose pipeline depths are timed by a shared counter.
module fp_mac_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int MUL_LATENCY   = 5,
    parameter int ADD_LATENCY   = 7,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  acc_clear,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] dataa,
    input  logic [DATA_WIDTH-1:0] datab,
    input  logic [DATA_WIDTH-1:0] datac,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] acc
);
    localparam int EW   = (DATA_WIDTH == 64) ? 11 : ((DATA_WIDTH == 16) ? 5 : 8);
    localparam int MW   = DATA_WIDTH - 1 - EW;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;
    localparam int XW   = MW + 4;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_ADD    = 2'b01;
    localparam logic [1:0] MODE_MAC    = 2'b11;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, ADD_WAIT, DONE} state_t;

    // Round-to-nearest-even and range clamp; zero exponent flushes to signed zero.
    function automatic logic [DATA_WIDTH-1:0] fp_pack(input logic s, input int e,
            input logic [MW-1:0] m, input logic g, input logic st);
        logic [MW:0] r;
        int          ee;
        ee = e;
        r  = {1'b0, m} + {{MW{1'b0}}, g & (st | m[0])};
        if (r[MW]) ee = ee + 1;
        if (ee >= EMAX) return {s, {EW{1'b1}}, {MW{1'b0}}};
        if (ee <= 0) return {s, {(DATA_WIDTH-1){1'b0}}};
        return {s, ee[EW-1:0], r[MW-1:0]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fp_mul(input logic [DATA_WIDTH-1:0] a,
            input logic [DATA_WIDTH-1:0] b);
        logic [2*MW+1:0] p;
        logic            s;
        int              e;
        s = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
        if (a[DATA_WIDTH-2:MW] == '0 || b[DATA_WIDTH-2:MW] == '0)
            return {s, {(DATA_WIDTH-1){1'b0}}};
        p = {{(MW+1){1'b0}}, 1'b1, a[MW-1:0]} * {{(MW+1){1'b0}}, 1'b1, b[MW-1:0]};
        e = int'(a[DATA_WIDTH-2:MW]) + int'(b[DATA_WIDTH-2:MW]) - BIAS;
        if (p[2*MW+1]) e = e + 1;
        else p = p << 1;
        return fp_pack(s, e, p[2*MW:MW+1], p[MW], |p[MW-1:0]);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fp_add(input logic [DATA_WIDTH-1:0] a,
            input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] x, y;
        logic [XW-1:0]         big, sml, sh;
        logic [XW:0]           s;
        int                    e, d;
        if (a[DATA_WIDTH-2:MW] == '0) return b;
        if (b[DATA_WIDTH-2:MW] == '0) return a;
        if (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        e   = int'(x[DATA_WIDTH-2:MW]);
        d   = e - int'(y[DATA_WIDTH-2:MW]);
        big = {1'b1, x[MW-1:0], 3'b000};
        sml = {1'b1, y[MW-1:0], 3'b000};
        // Bits shifted out of the smaller operand collapse into the sticky LSB.
        if (d >= XW) begin
            sh = {{(XW-1){1'b0}}, 1'b1};
        end else begin
            sh = sml >> d;
            if ((sh << d) != sml) sh[0] = 1'b1;
        end
        if (x[DATA_WIDTH-1] == y[DATA_WIDTH-1]) s = {1'b0, big} + {1'b0, sh};
        else s = {1'b0, big} - {1'b0, sh};
        if (s == '0) return '0;
        if (s[XW]) begin
            s = {1'b0, s[XW:2], s[1] | s[0]};
            e = e + 1;
        end
        for (int i = 0; i < XW; i++) begin
            if (!s[XW-1]) begin
                s = s << 1;
                e = e - 1;
            end
        end
        return fp_pack(x[DATA_WIDTH-1], e, s[XW-2:3], s[2], s[1] | s[0]);
    endfunction

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATA_WIDTH-1:0]    prod_q, prod_d, result_q, result_d, acc_q, acc_d;
    logic [1:0]               mode_q, mode_d;
    logic                     clr_q, clr_d, overrun_q, overrun_d;
    logic                     mul_en, add_en;
    logic [DATA_WIDTH-1:0]    mul_out, add_x, add_y, add_out;

    assign mul_en  = (state_q == MUL_WAIT);
    assign add_en  = (state_q == ADD_WAIT);
    assign add_x   = (mode_q == MODE_ADD) ? a_q : prod_q;
    assign add_y   = (mode_q == MODE_MAC) ? (clr_q ? '0 : acc_q) : c_q;
    assign mul_out = mul_en ? fp_mul(a_q, b_q) : '0;
    assign add_out = add_en ? fp_add(add_x, add_y) : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        mode_d    = mode_q;
        clr_d     = clr_q;
        prod_d    = prod_q;
        result_d  = result_q;
        acc_d     = acc_q;
        overrun_d = (state_q != IDLE) && start && !abort;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    a_d    = dataa;
                    b_d    = datab;
                    c_d    = datac;
                    mode_d = mode;
                    clr_d  = acc_clear;
                    if (mode == MODE_ADD) begin
                        state_d = ADD_WAIT;
                        cnt_d   = COUNTER_WIDTH'(ADD_LATENCY);
                    end else begin
                        state_d = MUL_WAIT;
                        cnt_d   = COUNTER_WIDTH'(MUL_LATENCY);
                    end
                end
            end
            MUL_WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (mode_q == MODE_MUL) begin
                        result_d = mul_out;
                        state_d  = DONE;
                    end else begin
                        // The hand-over edge already counts as the first adder cycle.
                        prod_d  = mul_out;
                        cnt_d   = COUNTER_WIDTH'(ADD_LATENCY - 1);
                        state_d = ADD_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ADD_WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    result_d = add_out;
                    if (mode_q == MODE_MAC) acc_d = add_out;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            mode_q    <= '0;
            clr_q     <= 1'b0;
            prod_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            mode_q    <= mode_d;
            clr_q     <= clr_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign overrun = overrun_q;
    assign result  = result_q;
    assign acc     = acc_q;
endmodule

// File: tb/tb_fp_mac_seq.sv
// Directed bench for fp_mac_seq: a vector table of single operations followed by
// hand-written overrun, abort and mid-operation reset sequences.
module tb_fp_mac_seq;
    logic        clock = 1'b0;
    logic        aclr_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        acc_clear = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] dataa = '0, datab = '0, datac = '0;
    logic        busy, done, overrun;
    logic [31:0] result, acc;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] F0  = 32'h00000000;
    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F7  = 32'h40E00000;
    localparam logic [31:0] F11 = 32'h41300000;
    localparam logic [31:0] F12 = 32'h41400000;
    localparam logic [31:0] FM2 = 32'hC0000000;

    fp_mac_seq #(
        .DATA_WIDTH(32), .MUL_LATENCY(5), .ADD_LATENCY(7), .COUNTER_WIDTH(4)
    ) dut (
        .clock(clock), .aclr_n(aclr_n), .start(start), .mode(mode),
        .acc_clear(acc_clear), .abort(abort), .dataa(dataa), .datab(datab),
        .datac(datac), .busy(busy), .done(done), .overrun(overrun),
        .result(result), .acc(acc)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic        clr;
        logic [31:0] a, b, c;
        logic [31:0] res, acc;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [1:0] m, input logic cl,
            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
            input logic [31:0] r, input logic [31:0] ac, input int lat);
        vec_t v;
        v.name = n; v.mode = m; v.clr = cl; v.a = a; v.b = b; v.c = c;
        v.res = r; v.acc = ac; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input vec_t v, input int inj, input int quiet);
        int   edges, ndone, extra;
        logic busy_ok, idle_ok, seen;
        mode = v.mode; acc_clear = v.clr; dataa = v.a; datab = v.b; datac = v.c;
        start = 1'b1;
        tick();
        start = 1'b0;
        dataa = 32'hDEADBEEF; datab = 32'h12345678; datac = 32'hCAFEF00D;
        mode = ~v.mode; acc_clear = ~v.clr;
        edges = 0; ndone = 0; seen = 1'b0; busy_ok = busy;
        while (!seen && edges < 40) begin
            if (edges == inj) start = 1'b1;
            tick();
            edges++;
            if (inj >= 0 && edges == inj + 1) begin
                start = 1'b0;
                chk({v.name, "_overrun_pulse"}, {31'b0, overrun}, 32'd1);
            end
            if (inj >= 0 && edges == inj + 2)
                chk({v.name, "_overrun_clear"}, {31'b0, overrun}, 32'd0);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
                ndone++;
            end
        end
        chk({v.name, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({v.name, "_latency"}, edges, v.lat);
        chk({v.name, "_result"}, result, v.res);
        chk({v.name, "_acc"}, acc, v.acc);
        chk({v.name, "_busy_during"}, {31'b0, busy_ok}, 32'd1);
        extra = 0; idle_ok = 1'b1;
        for (int i = 0; i < quiet; i++) begin
            tick();
            if (done) extra++;
            if (busy) idle_ok = 1'b0;
        end
        chk({v.name, "_no_extra_done"}, extra, 0);
        chk({v.name, "_idle_after"}, {31'b0, idle_ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        vec_t ovr, post;
        int   cnt;

        vecs[0] = mk("mul",      2'b00, 1'b0, F2, F3, F1, F6,  F0,  6);
        vecs[1] = mk("add",      2'b01, 1'b0, F1, F3, F4, F5,  F0,  8);
        vecs[2] = mk("muladd",   2'b10, 1'b0, F2, F3, F1, F7,  F0,  13);
        vecs[3] = mk("mac_clr",  2'b11, 1'b1, F2, F3, F5, F6,  F6,  13);
        vecs[4] = mk("mac_1x1",  2'b11, 1'b0, F1, F1, F5, F7,  F7,  13);
        vecs[5] = mk("mac_2x2",  2'b11, 1'b0, F2, F2, F5, F11, F11, 13);
        vecs[6] = mk("mul_clr",  2'b00, 1'b1, F3, F4, F1, F12, F11, 6);
        vecs[7] = mk("add_neg",  2'b01, 1'b1, F5, F1, FM2, F3, F11, 8);
        vecs[8] = mk("mul_zero", 2'b00, 1'b0, F0, F3, F1, F0,  F11, 6);

        // reset state
        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_result", result, F0);
        chk("rst_acc", acc, F0);
        tick();
        tick();
        aclr_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_op(vecs[i], -1, 3);

        // start pulsed while a MULADD is in flight
        ovr = mk("ovr_muladd", 2'b10, 1'b0, F2, F3, F1, F7, F11, 13);
        run_op(ovr, 4, 16);

        // abort during ADD_WAIT
        mode = 2'b01; dataa = F1; datab = F1; datac = F4; acc_clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        chk("abort_result", result, F7);
        chk("abort_acc", acc, F11);

        // abort together with start in IDLE
        abort = 1'b1; start = 1'b1; mode = 2'b00; dataa = F2; datab = F2;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", {31'b0, busy}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) cnt++;
        end
        chk("abort_start_no_done", cnt, 0);
        chk("abort_start_result", result, F7);

        // asynchronous reset while in MUL_WAIT
        mode = 2'b00; dataa = F2; datab = F3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 aclr_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_overrun", {31'b0, overrun}, 32'd0);
        chk("arst_result", result, F0);
        chk("arst_acc", acc, F0);
        tick(); tick();
        aclr_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("arst_no_done", cnt, 0);
        chk("arst_result_held", result, F0);

        post = mk("post_rst_mul", 2'b00, 1'b0, F2, F3, F1, F6, F0, 6);
        run_op(post, -1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
